// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_state_e  : FSM state encoding
//   SIZE_*       : request size codes (byte, half, word, double)
//   size_bytes() : number of bytes touched by a given size code
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane helper for the load/store unit.
//   i_size     : access size code
//   i_unsigned : loads: 1 = zero-extend, 0 = sign-extend
//   i_old      : 64-bit window previously read from memory (store merge)
//   i_wdata    : store data, low bytes used according to i_size
//   i_rdata    : 64-bit window read from memory (load extract)
//   o_merged   : low size_bytes(i_size) bytes from i_wdata, the rest from i_old
//   o_extended : low bytes of i_rdata extended to 64 bits
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_old,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_merged,
  output logic [63:0] o_extended
);

  // NOTE: every output of an always_comb gets a full default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(size_bytes(i_size))) begin
        o_merged[8*i +: 8] = i_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    o_extended = i_rdata;
    case (i_size)
      SIZE_B: o_extended = i_unsigned ? {56'd0, i_rdata[7:0]}
                                      : {{56{i_rdata[7]}}, i_rdata[7:0]};
      SIZE_H: o_extended = i_unsigned ? {48'd0, i_rdata[15:0]}
                                      : {{48{i_rdata[15]}}, i_rdata[15:0]};
      SIZE_W: o_extended = i_unsigned ? {32'd0, i_rdata[31:0]}
                                      : {{32{i_rdata[31]}}, i_rdata[31:0]};
      SIZE_D: o_extended = i_rdata;  // full width, signedness irrelevant
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a 64-bit byte-addressed
// data memory that always reads and writes a full 8-byte window.
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata                 : request fields, captured on accept
//   resp_valid/resp_ready     : response handshake, response held until taken
//   resp_rdata, resp_fault    : extended load data / out-of-bounds flag
//   mem_*                     : data memory port (combinational read data)
// Sub-doubleword stores read the window first and write back the merge.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  // Highest legal start address: the memory always touches 8 bytes.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

  lsu_state_e        r_state;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_old;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_fault;

  logic              w_accept;
  logic              w_fault;
  logic              w_mem_active;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_extended;

  assign req_ready    = (r_state == ST_IDLE);
  assign w_accept     = req_valid && req_ready;
  assign w_fault      = (req_addr > MAX_ADDR);  // full-width compare, no wrap

  lsu_align u_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_old      (r_old),
    .i_wdata    (r_wdata),
    .i_rdata    (mem_read_data),
    .o_merged   (w_merged),
    .o_extended (w_extended)
  );

  // Memory controls decode straight from the state register so an async
  // reset drops them at once; read and write states are disjoint.
  assign mem_read_enable  = (r_state == ST_LOAD) || (r_state == ST_RMW_RD);
  assign mem_write_enable = (r_state == ST_WRITE);
  assign w_mem_active     = mem_read_enable || mem_write_enable;
  assign mem_address      = w_mem_active ? r_addr : '0;
  // For size D the merge takes every byte from the store data, so the
  // (unread) old window never reaches memory.
  assign mem_write_data   = mem_write_enable ? w_merged : '0;

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_fault = r_resp_fault;

  // NOTE: state is updated with non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_size       <= SIZE_B;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_old        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            if (w_fault) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!req_write) begin
              r_state <= ST_LOAD;
            end else if (req_size == SIZE_D) begin
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          r_resp_rdata <= w_extended;
          r_resp_fault <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_old   <= mem_read_data;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_resp_rdata <= '0;
          r_resp_fault <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_fault <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 128-byte behavioural memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  logic [7:0]  mem [128];
  int          wr_cnt;
  int          rd_cnt;
  int          checks;
  int          failures;

  load_store_unit #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(128)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational little-endian 8-byte read window.
  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (mem_address + 64'(i) < 64'd128) begin
        mem_read_data[8*i +: 8] = mem[mem_address[6:0] + 7'(i)];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_read_enable) rd_cnt++;
    if (mem_write_enable) begin
      wr_cnt++;
      for (int i = 0; i < 8; i++) begin
        if (mem_address + 64'(i) < 64'd128) begin
          mem[mem_address[6:0] + 7'(i)] = mem_write_data[8*i +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic set_dword(input int a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[a+i] = v[8*i +: 8];
  endtask

  // Issue one request; return edges from accept to the first edge seeing
  // resp_valid, plus the response fields sampled mid-cycle.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] d,
                        output int lat, output logic [63:0] rd, output logic flt);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 8);
    rd  = resp_rdata;
    flt = resp_fault;
  endtask

  int          lat;
  logic [63:0] rd;
  logic        flt;
  int          wr0;
  int          rd0;
  logic [7:0]  snap [16];
  logic        same;

  initial begin
    checks = 0; failures = 0; wr_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    set_dword(0,   64'h44332211ffeeddcc);
    set_dword(8,   64'h88776655ddccbbaa);
    set_dword(120, 64'h7766554480000001);
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SIZE_B;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_fault", 64'(resp_fault), 64'd0);
    check("rst_enables", {62'd0, mem_read_enable, mem_write_enable}, 64'd0);
    check("rst_mem_address", mem_address, 64'd0);
    check("rst_mem_wdata", mem_write_data, 64'd0);
    rst_n = 1'b1;

    // Loads
    do_req(1'b0, SIZE_B, 1'b0, 64'd0, 64'd0, lat, rd, flt);
    check("ldb_s0_lat", 64'(lat), 64'd2);
    check("ldb_s0_data", rd, 64'hffffffffffffffcc);
    check("ldb_s0_fault", 64'(flt), 64'd0);
    do_req(1'b0, SIZE_H, 1'b1, 64'd2, 64'd0, lat, rd, flt);
    check("ldh_u2_data", rd, 64'h000000000000ffee);
    do_req(1'b0, SIZE_D, 1'b1, 64'd0, 64'd0, lat, rd, flt);
    check("ldd_0_data", rd, 64'h44332211ffeeddcc);

    // Store B via read-modify-write
    wr0 = wr_cnt;
    do_req(1'b1, SIZE_B, 1'b0, 64'd8, 64'h123456789abcde5a, lat, rd, flt);
    check("stb_8_lat", 64'(lat), 64'd3);
    @(negedge clk);
    check("stb_8_writes", 64'(wr_cnt - wr0), 64'd1);
    check("stb_8_rdata", rd, 64'd0);
    do_req(1'b0, SIZE_D, 1'b0, 64'd8, 64'd0, lat, rd, flt);
    check("ldd_8_after_stb", rd, 64'h88776655ddccbb5a);

    // Store H at an unaligned address, then read the surrounding dword
    do_req(1'b1, SIZE_H, 1'b0, 64'd3, 64'hffffffffffffbeef, lat, rd, flt);
    do_req(1'b0, SIZE_D, 1'b0, 64'd0, 64'd0, lat, rd, flt);
    check("ldd_0_after_sth", rd, 64'h443322beefeeddcc);

    // Store D: direct write, two-edge latency
    wr0 = wr_cnt;
    do_req(1'b1, SIZE_D, 1'b0, 64'd16, 64'h1122334455667788, lat, rd, flt);
    check("std_16_lat", 64'(lat), 64'd2);
    @(negedge clk);
    check("std_16_writes", 64'(wr_cnt - wr0), 64'd1);
    do_req(1'b0, SIZE_B, 1'b1, 64'd16, 64'd0, lat, rd, flt);
    check("ldb_u16_data", rd, 64'h0000000000000088);
    do_req(1'b0, SIZE_B, 1'b0, 64'd16, 64'd0, lat, rd, flt);
    check("ldb_s16_data", rd, 64'hffffffffffffff88);

    // Bounds: 121 faults, 120 is the last legal start, huge address no wrap
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req(1'b0, SIZE_W, 1'b0, 64'd121, 64'd0, lat, rd, flt);
    check("ldw_121_lat", 64'(lat), 64'd1);
    check("ldw_121_fault", 64'(flt), 64'd1);
    check("ldw_121_rdata", rd, 64'd0);
    @(negedge clk);
    check("ldw_121_no_access", 64'(rd_cnt - rd0 + wr_cnt - wr0), 64'd0);
    do_req(1'b0, SIZE_W, 1'b0, 64'd120, 64'd0, lat, rd, flt);
    check("ldw_s120_fault", 64'(flt), 64'd0);
    check("ldw_s120_data", rd, 64'hffffffff80000001);
    do_req(1'b0, SIZE_W, 1'b1, 64'd120, 64'd0, lat, rd, flt);
    check("ldw_u120_data", rd, 64'h0000000080000001);
    wr0 = wr_cnt;
    do_req(1'b1, SIZE_B, 1'b0, 64'h8000000000000000, 64'hff, lat, rd, flt);
    check("stb_huge_fault", 64'(flt), 64'd1);
    @(negedge clk);
    check("stb_huge_no_write", 64'(wr_cnt - wr0), 64'd0);

    // Response back-pressure: held three cycles, taken on the fourth
    resp_ready = 1'b0;
    do_req(1'b0, SIZE_D, 1'b0, 64'd0, 64'd0, lat, rd, flt);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_data", resp_rdata, 64'h443322beefeeddcc);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_released_valid", 64'(resp_valid), 64'd0);
    check("hold_released_ready", 64'(req_ready), 64'd1);

    // Async reset in the middle of a read-modify-write
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_B; req_unsigned = 1'b0;
    req_addr = 64'd0; req_wdata = 64'h99;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rmw_rd_read_en", 64'(mem_read_enable), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rmw_rst_enables", {62'd0, mem_read_enable, mem_write_enable}, 64'd0);
    check("rmw_rst_req_ready", 64'(req_ready), 64'd1);
    check("rmw_rst_mem_address", mem_address, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    same = 1'b1;
    for (int i = 0; i < 16; i++) if (mem[i] !== snap[i]) same = 1'b0;
    check("rmw_rst_mem_unchanged", 64'(same), 64'd1);
    check("rmw_rst_no_write", 64'(wr_cnt - wr0), 64'd0);
    do_req(1'b0, SIZE_B, 1'b1, 64'd0, 64'd0, lat, rd, flt);
    check("post_rst_ldb", rd, 64'h00000000000000cc);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
